// File: rtl/sram_output_acc.sv
// ---------------------------------------------------------------------------
// sram_output_acc
//
// Output buffer for the accelerator datapath. A simple dual-port word memory
// with one write port and one registered-address read port. Every write
// either overwrites the stored word or accumulates into it with signed
// saturation; any clamp sets a sticky overflow flag. A built-in clear engine
// zero-fills the array after reset (optional) or on request.
//
// Parameters
//   DWIDTH          data word width, signed two's complement
//   ADDRW           address width, depth WORDS = 2**ADDRW
//   CLEAR_ON_RESET  1 = zero-fill starts on reset, 0 = reset leaves the array
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   clear     one-cycle request to zero-fill the whole array
//   busy      high while the zero-fill runs
//   wr_en     write request
//   wr_acc    0 = overwrite, 1 = accumulate with saturation
//   wr_addr   write address
//   wr_data   signed write operand
//   rd_en     read request
//   rd_addr   read address
//   rd_data   mem[registered read address]
//   rd_valid  rd_data qualifies the read captured on the previous edge
//   ovf       sticky saturation flag
// ---------------------------------------------------------------------------
module sram_output_acc #(
    parameter int DWIDTH         = 16,
    parameter int ADDRW          = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    input  logic              wr_en,
    input  logic              wr_acc,
    input  logic [ADDRW-1:0]  wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDRW-1:0]  rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              ovf
);

    localparam int WORDS = 2 ** ADDRW;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Signed add in DWIDTH+1 bits, clamped to the DWIDTH range.
    // Returns {clamped, result}.
    function automatic logic [DWIDTH:0] sat_add(
        input logic [DWIDTH-1:0] a,
        input logic [DWIDTH-1:0] b
    );
        logic [DWIDTH:0]   sum;
        logic [DWIDTH-1:0] res;
        logic              clamp;
        sum = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        // The two top bits differ exactly when the sum left the DWIDTH range;
        // the extra top bit then holds the true sign of the result.
        if (sum[DWIDTH] != sum[DWIDTH-1]) begin
            clamp = 1'b1;
            if (sum[DWIDTH]) begin
                res = {1'b1, {(DWIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(DWIDTH-1){1'b1}}};
            end
        end else begin
            clamp = 1'b0;
            res   = sum[DWIDTH-1:0];
        end
        return {clamp, res};
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDRW-1:0]   clr_cnt_r;
    logic               clr_last_s;

    logic               clear_ok_s;
    logic               wr_ok_s;
    logic               rd_ok_s;

    logic               s1_valid_r;
    logic               s1_acc_r;
    logic [ADDRW-1:0]   s1_addr_r;
    logic [DWIDTH-1:0]  s1_data_r;
    logic [DWIDTH-1:0]  commit_data_s;
    logic               commit_ovf_s;

    logic [DWIDTH-1:0]  mem_r [WORDS];
    logic [ADDRW-1:0]   rd_addr_r;
    logic               rd_valid_r;
    logic               ovf_r;

    // Request qualification: nothing is accepted while the fill runs, and a
    // clear arriving with a write wins, so the write is lost.
    always_comb begin
        clr_last_s = (clr_cnt_r == {ADDRW{1'b1}});
        clear_ok_s = (state_r == ST_IDLE) && clear;
        wr_ok_s    = (state_r == ST_IDLE) && !clear && wr_en;
        rd_ok_s    = (state_r == ST_IDLE) && rd_en;
    end

    // Next-state logic of the clear engine.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and fill address counter; reset restarts the fill at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            // Counter wraps to 0 naturally on the last fill word.
            if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + {{(ADDRW-1){1'b0}}, 1'b1};
            end else begin
                clr_cnt_r <= '0;
            end
        end
    end

    // Write stage S1: capture an accepted write for commit on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_acc_r   <= 1'b0;
            s1_addr_r  <= '0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= wr_ok_s;
            if (wr_ok_s) begin
                s1_acc_r  <= wr_acc;
                s1_addr_r <= wr_addr;
                s1_data_r <= wr_data;
            end
        end
    end

    // Commit value. The accumulate operand is read from the array at commit
    // time, so a commit on the previous edge is already visible here and
    // back-to-back accumulates to one address need no forwarding.
    always_comb begin
        commit_data_s = s1_data_r;
        commit_ovf_s  = 1'b0;
        if (s1_acc_r) begin
            {commit_ovf_s, commit_data_s} = sat_add(mem_r[s1_addr_r], s1_data_r);
        end else begin
            commit_data_s = s1_data_r;
            commit_ovf_s  = 1'b0;
        end
    end

    // Memory array write port: fill has priority; reset blocks all writes
    // so an in-flight S1 op is dropped. The array itself is not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_cnt_r] <= '0;
            end else if (s1_valid_r) begin
                mem_r[s1_addr_r] <= commit_data_s;
            end
        end
    end

    // Sticky overflow; an accepted clear wipes it even if a clamping commit
    // lands on the same edge, since that word is zeroed by the fill anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (clear_ok_s) begin
            ovf_r <= 1'b0;
        end else if (s1_valid_r && commit_ovf_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Read address register and valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_addr_r  <= '0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_addr_r <= rd_addr;
            end
        end
    end

    // Read data follows the array combinationally, so it reflects every
    // commit up to and including the edge that registered the address.
    assign rd_data  = mem_r[rd_addr_r];
    assign rd_valid = rd_valid_r;
    assign ovf      = ovf_r;
    assign busy     = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_sram_output_acc.sv
module tb_sram_output_acc;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int WORDS = 16;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          busy;
    logic          wr_en;
    logic          wr_acc;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          ovf;

    int tests;
    int failed;

    // Reference model: plain integer array plus sticky flag.
    int model [WORDS];
    bit ovf_m;

    sram_output_acc #(
        .DWIDTH(DW),
        .ADDRW(AW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .busy(busy),
        .wr_en(wr_en),
        .wr_acc(wr_acc),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < WORDS; i++) model[i] = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_write(input int a, input int d, input bit acc);
        int s;
        if (acc) begin
            s = model[a] + d;
            if (s > 32767) begin
                s = 32767;
                ovf_m = 1'b1;
            end else if (s < -32768) begin
                s = -32768;
                ovf_m = 1'b1;
            end
            model[a] = s;
        end else begin
            model[a] = d;
        end
    endtask

    task automatic wr(input int a, input int d, input bit acc);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d[DW-1:0];
        wr_acc  = acc;
        tick();
        wr_en = 1'b0;
        model_write(a, d, acc);
    endtask

    task automatic rd(input int a, input string tag);
        rd_en   = 1'b1;
        rd_addr = a[AW-1:0];
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'sd1);
        check(tag, $signed(rd_data), model[a]);
    endtask

    // Count edges while busy stays high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int a;
        int ra;
        int d;
        bit we;
        bit acc;
        logic signed [15:0] r16;

        tests   = 0;
        failed  = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_acc  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        model_zero();

        // Reset for two cycles, then the automatic fill.
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'sd1);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'sd0);
        check("rst_ovf", {31'd0, ovf}, 32'sd0);
        rst = 1'b0;
        wait_idle(n);
        check("rst_fill_len", n, 32'sd16);
        for (int i = 0; i < WORDS; i++) rd(i, "rst_zero");
        check("rst_ovf_after", {31'd0, ovf}, 32'sd0);

        // Overwrite then read one cycle later.
        wr(3, -5, 1'b0);
        rd(3, "overwrite");
        tick();
        check("rd_valid_idle", {31'd0, rd_valid}, 32'sd0);

        // Back-to-back accumulates to one address.
        wr(7, 100, 1'b1);
        wr(7, 200, 1'b1);
        wr(7, 300, 1'b1);
        rd(7, "acc_600");
        check("acc_expect", model[7], 32'sd600);
        check("acc_ovf", {31'd0, ovf}, 32'sd0);

        // Saturation both ways, then clear resets ovf.
        wr(2, 32000, 1'b0);
        wr(2, 1000, 1'b1);
        rd(2, "sat_pos");
        check("sat_ovf", {31'd0, ovf}, 32'sd1);
        wr(4, -32000, 1'b0);
        wr(4, -1000, 1'b1);
        rd(4, "sat_neg");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        wait_idle(n);
        check("clr_len", n, 32'sd16);
        check("clr_ovf", {31'd0, ovf}, 32'sd0);
        rd(2, "clr_zero");

        // Same-edge read and write to one address returns the old value.
        wr(5, 9, 1'b0);
        wr_en   = 1'b1;
        wr_acc  = 1'b0;
        wr_addr = 4'd5;
        wr_data = 16'd77;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("hazard_old", $signed(rd_data), 32'sd9);
        model_write(5, 77, 1'b0);
        rd(5, "hazard_new");

        // Clear together with a write: write lost, in-flight commit zeroed.
        wr(1, 123, 1'b0);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 16'd55;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        model_zero();
        wait_idle(n);
        check("clrwr_len", n, 32'sd16);
        rd(1, "clrwr_zero");

        // Reset at fill cycle 8 restarts the fill; requests while busy dropped.
        wr(9, 4321, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy", {31'd0, busy}, 32'sd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        wr_en   = 1'b1;
        wr_acc  = 1'b0;
        wr_addr = 4'd9;
        wr_data = 16'd999;
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        wait_idle(n);
        check("mid_fill_len", n, 32'sd16);
        check("busy_rd_dropped", {31'd0, rd_valid}, 32'sd0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rd(9, "busy_wr_dropped");

        // Random mix of writes and reads against the model.
        for (int i = 0; i < 60; i++) begin
            a   = $urandom_range(0, WORDS - 1);
            ra  = $urandom_range(0, WORDS - 1);
            acc = 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: d = $urandom_range(20000, 32767);
                1: d = -int'($urandom_range(20000, 32768));
                default: begin
                    r16 = 16'($urandom);
                    d   = r16;
                end
            endcase
            wr_en   = we;
            wr_acc  = acc;
            wr_addr = a[AW-1:0];
            wr_data = d[DW-1:0];
            rd_en   = 1'b1;
            rd_addr = ra[AW-1:0];
            tick();
            check("rand_rd", $signed(rd_data), model[ra]);
            if (we) model_write(a, d, acc);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        check("rand_ovf", {31'd0, ovf}, {31'd0, ovf_m});
        for (int i = 0; i < WORDS; i++) rd(i, "rand_final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
